// File: rtl/breakout_pkg.sv
// Shared breakout game encodings and default sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package breakout_pkg;

    typedef enum logic [2:0] {
        SERVE = 3'd0,
        PLAY  = 3'd1,
        LOST  = 3'd2,
        WIN   = 3'd3,
        OVER  = 3'd4
    } game_state_e;

    localparam int         NUM_BRICKS_DFLT  = 12;
    localparam logic [1:0] START_LIVES_DFLT = 2'd3;
    localparam logic [9:0] NO_BRICK_CODE    = 10'd15;

endpackage

// File: rtl/brick_tracker_score_counter.sv
// Saturating score register; packed BCD when BRICK_TRACKER_SCORE_BCD_EN is defined, else binary.
// Latency: score reflects clr/inc one clk after the qualifying edge.
// Backpressure: none; inc is accepted every cycle, clr wins over inc.
module score_counter
    import breakout_pkg::*;
#(
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    output logic [SCORE_W-1:0] score
);

    logic [SCORE_W-1:0] score_nxt;

`ifdef BRICK_TRACKER_SCORE_BCD_EN
    localparam int                 DIGITS    = SCORE_W / 4;
    localparam logic [SCORE_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    logic bcd_carry;

    // Ripple a +1 through the digits; stop once a digit absorbs the carry.
    always_comb begin
        score_nxt = score;
        bcd_carry = 1'b1;
        if (score != ALL_NINES) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (bcd_carry) begin
                    if (score[4*d +: 4] == 4'd9) begin
                        score_nxt[4*d +: 4] = 4'd0;
                    end else begin
                        score_nxt[4*d +: 4] = score[4*d +: 4] + 4'd1;
                        bcd_carry           = 1'b0;
                    end
                end
            end
        end
    end
`else
    always_comb begin
        score_nxt = (score == '1) ? score : score + 1'b1;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score <= '0;
        end else if (clr) begin
            score <= '0;
        end else if (inc) begin
            score <= score_nxt;
        end
    end

endmodule

// File: rtl/brick_tracker.sv
// Breakout brick/score/lives tracker and game FSM; BCD score via BRICK_TRACKER_SCORE_BCD_EN.
// Latency: all outputs registered, updated 1 clk after a tick edge; ball_serve is a 1-clk pulse.
// Backpressure: none; inputs are sampled only on tick and never stalled.
module brick_tracker
    import breakout_pkg::*;
#(
    parameter int         NUM_BRICKS  = NUM_BRICKS_DFLT,
    parameter int         SCORE_W     = 8,
    parameter logic [1:0] START_LIVES = START_LIVES_DFLT,
    parameter logic [9:0] LOST_Y      = 10'd2,
    parameter logic [9:0] NO_BRICK    = NO_BRICK_CODE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  start,
    input  logic [9:0]            ball_x,
    input  logic [9:0]            ball_y,
    input  logic [9:0]            brick_num,
    output logic [NUM_BRICKS-1:0] brick_status,
    output logic [SCORE_W-1:0]    score,
    output logic [1:0]            lives,
    output logic [2:0]            game_state,
    output logic                  ball_en,
    output logic                  ball_serve
);

    game_state_e           state;
    logic [NUM_BRICKS-1:0] hit_mask;
    logic [NUM_BRICKS-1:0] bricks_left;
    logic                  hit;
    logic                  score_inc;
    logic                  score_clr;
    logic                  unused_ball_x;

    // Horizontal position plays no part in brick bookkeeping.
    assign unused_ball_x = ^ball_x;

    // One-hot decode; out-of-range indices (NO_BRICK included) decode to nothing.
    always_comb begin
        hit_mask = '0;
        if (brick_num != NO_BRICK) begin
            for (int i = 0; i < NUM_BRICKS; i++) begin
                if (brick_num == 10'(i)) hit_mask[i] = 1'b1;
            end
        end
    end

    assign hit         = |(hit_mask & brick_status);
    assign bricks_left = brick_status & ~hit_mask;
    assign score_inc   = tick && (state == PLAY) && hit;
    assign score_clr   = tick && start && ((state == WIN) || (state == OVER));
    assign game_state  = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= SERVE;
            brick_status <= '1;
            lives        <= START_LIVES;
            ball_en      <= 1'b0;
            ball_serve   <= 1'b0;
        end else begin
            ball_serve <= 1'b0;
            if (tick) begin
                case (state)
                    SERVE: begin
                        if (start) begin
                            ball_serve <= 1'b1;
                            ball_en    <= 1'b1;
                            state      <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (hit) brick_status <= bricks_left;
                        // Clearing the last brick outranks losing the ball on the same tick.
                        if (hit && (bricks_left == '0)) begin
                            ball_en <= 1'b0;
                            state   <= WIN;
                        end else if (ball_y < LOST_Y) begin
                            ball_en <= 1'b0;
                            state   <= LOST;
                        end
                    end
                    LOST: begin
                        if (lives <= 2'd1) begin
                            lives <= 2'd0;
                            state <= OVER;
                        end else begin
                            lives <= lives - 2'd1;
                            state <= SERVE;
                        end
                    end
                    WIN, OVER: begin
                        if (start) begin
                            brick_status <= '1;
                            lives        <= START_LIVES;
                            ball_serve   <= 1'b1;
                            ball_en      <= 1'b1;
                            state        <= PLAY;
                        end
                    end
                    default: begin
                        ball_en <= 1'b0;
                        state   <= SERVE;
                    end
                endcase
            end
        end
    end

    score_counter #(
        .SCORE_W(SCORE_W)
    ) u_score (
        .clk  (clk),
        .reset(reset),
        .clr  (score_clr),
        .inc  (score_inc),
        .score(score)
    );

endmodule

// File: tb/tb_brick_tracker.sv
// Scoreboarded random + directed bench for brick_tracker against a game-rule reference model.
module tb_brick_tracker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  ball_x = '0;
    logic [9:0]  ball_y = 10'd100;
    logic [9:0]  brick_num = 10'd15;
    logic [9:0]  brick_num2 = 10'd1023;

    logic [11:0] brick_status;
    logic [7:0]  score;
    logic [1:0]  lives;
    logic [2:0]  game_state;
    logic        ball_en, ball_serve;

    logic [19:0] s_status;
    logic [3:0]  s_score;
    logic [1:0]  s_lives;
    logic [2:0]  s_state;
    logic        s_en, s_serve;

    always #5 clk = ~clk;

    brick_tracker u_dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start),
        .ball_x(ball_x), .ball_y(ball_y), .brick_num(brick_num),
        .brick_status(brick_status), .score(score), .lives(lives),
        .game_state(game_state), .ball_en(ball_en), .ball_serve(ball_serve)
    );

    // Narrow-score, wide-field instance used only to reach score saturation.
    brick_tracker #(.NUM_BRICKS(20), .SCORE_W(4)) u_sat (
        .clk(clk), .reset(reset), .tick(tick), .start(start),
        .ball_x(ball_x), .ball_y(ball_y), .brick_num(brick_num2),
        .brick_status(s_status), .score(s_score), .lives(s_lives),
        .game_state(s_state), .ball_en(s_en), .ball_serve(s_serve)
    );

    typedef struct {
        logic [11:0] bricks;
        logic [7:0]  score;
        logic [1:0]  lives;
        logic [2:0]  st;
        logic        en;
        logic        serve;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int passed = 0;

    // Reference model state: game-level quantities only.
    int       m_state;
    bit [11:0] m_bricks;
    int       m_hits;
    int       m_lives;
    bit       m_en, m_serve;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    // Displayed score for a number of bricks cleared, given the register width.
    function automatic int exp_score(input int hits, input int w);
        int mx, v, r;
`ifdef BRICK_TRACKER_SCORE_BCD_EN
        mx = 1;
        for (int i = 0; i < w / 4; i++) mx = mx * 10;
        mx = mx - 1;
        v  = (hits > mx) ? mx : hits;
        r  = 0;
        for (int d = 0; d < w / 4; d++) begin
            r = r + ((v % 10) << (4 * d));
            v = v / 10;
        end
`else
        mx = (1 << w) - 1;
        r  = (hits > mx) ? mx : hits;
        v  = 0;
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_bricks = 12'hFFF;
        m_hits   = 0;
        m_lives  = 3;
        m_en     = 1'b0;
        m_serve  = 1'b0;
    endtask

    task automatic drive(input bit t, input bit s, input int by, input int bn, input int bn2 = 1023);
        bit   hit;
        exp_t e;
        @(negedge clk);
        tick       = t;
        start      = s;
        ball_y     = by[9:0];
        brick_num  = bn[9:0];
        brick_num2 = bn2[9:0];
        ball_x     = 10'($urandom_range(0, 639));
        m_serve    = 1'b0;
        if (t) begin
            case (m_state)
                0: if (s) begin m_serve = 1'b1; m_en = 1'b1; m_state = 1; end
                1: begin
                    hit = (bn >= 0) && (bn < 12) && m_bricks[bn];
                    if (hit) begin m_bricks[bn] = 1'b0; m_hits++; end
                    if (hit && m_bricks == 12'h000) begin m_state = 3; m_en = 1'b0; end
                    else if (by < 2) begin m_state = 2; m_en = 1'b0; end
                end
                2: begin m_lives--; m_state = (m_lives == 0) ? 4 : 0; end
                default: if (s) begin
                    model_reset();
                    m_serve = 1'b1; m_en = 1'b1; m_state = 1;
                end
            endcase
        end
        e.bricks = m_bricks;
        e.score  = 8'(exp_score(m_hits, 8));
        e.lives  = 2'(m_lives);
        e.st     = 3'(m_state);
        e.en     = m_en;
        e.serve  = m_serve;
        exp_q.push_back(e);
    endtask

    // Asserts reset between clock edges and checks outputs before any edge arrives.
    task automatic pulse_reset();
        @(negedge clk);
        tick  = 1'b0;
        start = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_bricks", 32'(brick_status), 32'h0FFF);
        check("rst_score", 32'(score), 32'h0);
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_state", 32'(game_state), 32'd0);
        check("rst_en", 32'(ball_en), 32'd0);
        check("rst_serve", 32'(ball_serve), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Monitor: compares every registered output after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("brick_status", 32'(brick_status), 32'(e.bricks));
                check("score", 32'(score), 32'(e.score));
                check("lives", 32'(lives), 32'(e.lives));
                check("game_state", 32'(game_state), 32'(e.st));
                check("ball_en", 32'(ball_en), 32'(e.en));
                check("ball_serve", 32'(ball_serve), 32'(e.serve));
            end
        end
    end

    initial begin
        model_reset();
        pulse_reset();

        // Serve, repeated hit on brick 5, NO_BRICK, and a non-tick hit.
        drive(1, 1, 100, 15);
        drive(0, 0, 100, 15);
        drive(1, 0, 100, 5);
        drive(1, 0, 100, 5);
        drive(1, 0, 100, 15);
        drive(0, 0, 100, 6);

        // Mid-PLAY asynchronous reset.
        pulse_reset();

        // Clear every brick; the last hit coincides with a lost ball.
        drive(1, 1, 100, 15);
        for (int i = 0; i < 12; i++) drive(1, 0, (i == 11) ? 0 : 100, i);
        drive(1, 0, 0, 3);
        drive(1, 1, 100, 15);

        // Lose all lives, then restart from OVER.
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 15);
            drive(1, 0, 100, 15);
            if (k < 2) drive(1, 1, 100, 15);
        end
        drive(1, 0, 2, 15);
        drive(1, 1, 100, 15);
        drive(1, 0, 2, 7);

        repeat (4000) begin
            drive($urandom_range(0, 2) != 0,
                  $urandom_range(0, 3) == 0,
                  ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 479)),
                  ($urandom_range(0, 2) == 0) ? 15 : int'($urandom_range(0, 20)));
        end

        // Saturation on the 4-bit score instance.
        pulse_reset();
        drive(1, 1, 100, 15, 1023);
        for (int i = 0; i < 17; i++) drive(1, 0, 100, 15, i);
        @(posedge clk);
        #1;
        check("sat_score", 32'(s_score), 32'(exp_score(17, 4)));

        drive(0, 0, 100, 15);
        drive(0, 0, 100, 15);
        @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
